// File: rtl/riscv_lsu_if.sv
// Bundle of core-side and memory-side signals of the load-store unit.
// Handshake: the core raises core_req_i and holds every core_* input stable
// while core_stall_o=1. The access completes in the cycle where core_stall_o
// drops (release cycle, or an lsu_err_o pulse). Towards memory, mem_req_o is
// a one-cycle pulse, and mem_ready_i may answer at the earliest one cycle later.
interface riscv_lsu_if;
  logic        core_req_i;
  logic        core_we_i;
  logic [2:0]  core_size_i;
  logic [31:0] core_addr_i;
  logic [31:0] core_wd_i;
  logic [31:0] core_rd_o;
  logic        core_stall_o;
  logic        lsu_err_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wd_o;
  logic [31:0] mem_rd_i;
  logic        mem_ready_i;

  // LSU view
  modport master (
    input  core_req_i, core_we_i, core_size_i, core_addr_i, core_wd_i,
    input  mem_rd_i, mem_ready_i,
    output core_rd_o, core_stall_o, lsu_err_o,
    output mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wd_o
  );

  // Environment view (core + memory)
  modport slave (
    output core_req_i, core_we_i, core_size_i, core_addr_i, core_wd_i,
    output mem_rd_i, mem_ready_i,
    input  core_rd_o, core_stall_o, lsu_err_o,
    input  mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wd_o
  );
endinterface

// File: rtl/riscv_lsu.sv
// Load-store unit: turns sized byte-addressed core requests into word
// accesses with byte enables, extends load data and owns the core stall.
module riscv_lsu #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic         clk_i,
  input  logic         rst_i,
  riscv_lsu_if.master  bus,
  output logic         dbg_state_o
);

  typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_e;

  localparam logic [7:0] TIMEOUT_LIM = 8'(TIMEOUT_CYCLES);

  state_e      state_q, state_d;
  logic        we_q, we_d;
  logic [2:0]  size_q, size_d;
  logic [1:0]  off_q, off_d;
  logic [7:0]  cnt_q, cnt_d;

  logic        req_valid;
  logic [3:0]  be_raw;
  logic [31:0] wd_raw;
  logic [31:0] shifted;
  logic [31:0] load_data;
  logic        req_c, stall_c, err_c;
  logic [31:0] rd_c;

  // Request validity, byte enables and replicated store data from live core inputs
  always_comb begin
    req_valid = 1'b0;
    case (bus.core_size_i)
      3'd0, 3'd4: req_valid = 1'b1;
      3'd1, 3'd5: req_valid = ~bus.core_addr_i[0];
      3'd2:       req_valid = (bus.core_addr_i[1:0] == 2'b00);
      default:    req_valid = 1'b0;
    endcase
    case (bus.core_size_i[1:0])
      2'd0: begin
        be_raw = 4'b0001 << bus.core_addr_i[1:0];
        wd_raw = {4{bus.core_wd_i[7:0]}};
      end
      2'd1: begin
        be_raw = 4'b0011 << bus.core_addr_i[1:0];
        wd_raw = {2{bus.core_wd_i[15:0]}};
      end
      default: begin
        be_raw = 4'b1111;
        wd_raw = bus.core_wd_i;
      end
    endcase
  end

  // Load extraction from the latched offset and size
  always_comb begin
    shifted = bus.mem_rd_i >> {off_q, 3'b000};
    case (size_q)
      3'd0:    load_data = {{24{shifted[7]}}, shifted[7:0]};
      3'd1:    load_data = {{16{shifted[15]}}, shifted[15:0]};
      3'd4:    load_data = {24'b0, shifted[7:0]};
      3'd5:    load_data = {16'b0, shifted[15:0]};
      default: load_data = shifted;
    endcase
  end

  // FSM next state, latched fields, wait counter and combinational outputs
  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    size_d  = size_q;
    off_d   = off_q;
    cnt_d   = cnt_q;
    req_c   = 1'b0;
    stall_c = 1'b0;
    err_c   = 1'b0;
    rd_c    = 32'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.core_req_i) begin
          if (req_valid) begin
            req_c   = 1'b1;
            stall_c = 1'b1;
            we_d    = bus.core_we_i;
            size_d  = bus.core_size_i;
            off_d   = bus.core_addr_i[1:0];
            cnt_d   = 8'd0;
            state_d = S_WAIT;
          end else begin
            err_c = 1'b1;
          end
        end
      end
      S_WAIT: begin
        if (bus.mem_ready_i) begin
          // Release wins over a timeout in the same cycle
          if (!we_q) rd_c = load_data;
          state_d = S_IDLE;
        end else if ((TIMEOUT_LIM != 8'd0) && (cnt_q == TIMEOUT_LIM)) begin
          err_c   = 1'b1;
          state_d = S_IDLE;
        end else begin
          stall_c = 1'b1;
          if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output gating: everything is forced to 0 while reset is asserted
  assign bus.mem_req_o    = rst_i & req_c;
  assign bus.core_stall_o = rst_i & stall_c;
  assign bus.lsu_err_o    = rst_i & err_c;
  assign bus.core_rd_o    = rst_i ? rd_c : 32'b0;
  assign bus.mem_we_o     = bus.mem_req_o & bus.core_we_i;
  assign bus.mem_be_o     = bus.mem_req_o ? be_raw : 4'b0;
  assign bus.mem_wd_o     = bus.mem_req_o ? wd_raw : 32'b0;
  assign bus.mem_addr_o   = rst_i ? {bus.core_addr_i[31:2], 2'b00} : 32'b0;
  assign dbg_state_o      = state_q;

  // State and latched-field registers
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      size_q  <= 3'd0;
      off_q   <= 2'd0;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      size_q  <= size_d;
      off_q   <= off_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_riscv_lsu.sv
// Bench for riscv_lsu: directed vector table plus hand-written sequences
// for wait states, timeout, reset during WAIT and back-to-back requests.
module tb_riscv_lsu;

  logic clk;
  logic rst_n;
  logic dbg;
  int   n_checks;
  int   n_pass;
  logic [31:0] exp_q[$];

  riscv_lsu_if bus ();

  riscv_lsu #(.TIMEOUT_CYCLES(4)) dut (
    .clk_i       (clk),
    .rst_i       (rst_n),
    .bus         (bus),
    .dbg_state_o (dbg)
  );

  typedef struct {
    string       name;
    logic        we;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rdw;
    logic        err;
    logic [3:0]  be;
    logic [31:0] wdx;
    logic [31:0] rdx;
  } vec_t;

  vec_t vecs[14];

  // Clock and reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic drive_req(input logic we, input logic [2:0] sz, input logic [31:0] a,
                           input logic [31:0] wd);
    bus.core_req_i  = 1'b1;
    bus.core_we_i   = we;
    bus.core_size_i = sz;
    bus.core_addr_i = a;
    bus.core_wd_i   = wd;
  endtask

  task automatic drive_idle();
    bus.core_req_i  = 1'b0;
    bus.core_we_i   = 1'b0;
    bus.core_size_i = 3'd0;
    bus.core_addr_i = 32'h0;
    bus.core_wd_i   = 32'h0;
    bus.mem_ready_i = 1'b0;
    bus.mem_rd_i    = 32'h0;
  endtask

  // Scoreboard: compare a released load value against the oldest expectation
  task automatic sb_check(input string name);
    logic [31:0] e;
    if (exp_q.size() == 0) begin
      n_checks++;
      $display("FAIL %s: no expected value queued", name);
    end else begin
      e = exp_q.pop_front();
      check(name, bus.core_rd_o, e);
    end
  endtask

  initial begin
    int stalls;
    n_checks = 0;
    n_pass   = 0;
    rst_n    = 1'b0;
    drive_idle();

    //           name     we    sz    addr          wd            mem rd        err   be       wd exp        rd exp
    vecs[0]  = '{"lw100", 1'b0, 3'd2, 32'h0000_0100, 32'h0,        32'hDEAD_BEEF, 1'b0, 4'b1111, 32'h0,        32'hDEAD_BEEF};
    vecs[1]  = '{"lb103", 1'b0, 3'd0, 32'h0000_0103, 32'h0,        32'h8000_0000, 1'b0, 4'b1000, 32'h0,        32'hFFFF_FF80};
    vecs[2]  = '{"lbu103",1'b0, 3'd4, 32'h0000_0103, 32'h0,        32'h8000_0000, 1'b0, 4'b1000, 32'h0,        32'h0000_0080};
    vecs[3]  = '{"sh102", 1'b1, 3'd1, 32'h0000_0102, 32'h1234_ABCD, 32'h0,        1'b0, 4'b1100, 32'hABCD_ABCD, 32'h0};
    vecs[4]  = '{"lw102", 1'b0, 3'd2, 32'h0000_0102, 32'h0,        32'h0,        1'b1, 4'b0000, 32'h0,        32'h0};
    vecs[5]  = '{"sz3",   1'b0, 3'd3, 32'h0000_0100, 32'h0,        32'h0,        1'b1, 4'b0000, 32'h0,        32'h0};
    vecs[6]  = '{"lh102", 1'b0, 3'd1, 32'h0000_0102, 32'h0,        32'h8001_0000, 1'b0, 4'b1100, 32'h0,        32'hFFFF_8001};
    vecs[7]  = '{"lhu100",1'b0, 3'd5, 32'h0000_0100, 32'h0,        32'h1234_F00D, 1'b0, 4'b0011, 32'h0,        32'h0000_F00D};
    vecs[8]  = '{"sb101", 1'b1, 3'd0, 32'h0000_0101, 32'h0000_00A5, 32'h0,        1'b0, 4'b0010, 32'hA5A5_A5A5, 32'h0};
    vecs[9]  = '{"sw200", 1'b1, 3'd2, 32'h0000_0200, 32'hCAFE_F00D, 32'h0,        1'b0, 4'b1111, 32'hCAFE_F00D, 32'h0};
    vecs[10] = '{"lb101", 1'b0, 3'd0, 32'h0000_0101, 32'h0,        32'h0000_7F00, 1'b0, 4'b0010, 32'h0,        32'h0000_007F};
    vecs[11] = '{"lh101", 1'b0, 3'd1, 32'h0000_0101, 32'h0,        32'h0,        1'b1, 4'b0000, 32'h0,        32'h0};
    vecs[12] = '{"sz7",   1'b0, 3'd7, 32'h0000_0104, 32'h0,        32'h0,        1'b1, 4'b0000, 32'h0,        32'h0};
    vecs[13] = '{"sh103", 1'b1, 3'd1, 32'h0000_0103, 32'h1111_2222, 32'h0,        1'b1, 4'b0000, 32'h0,        32'h0};

    // Reset state
    #3;
    check("rst state", {31'b0, dbg}, 32'h0);
    check("rst stall", {31'b0, bus.core_stall_o}, 32'h0);
    check("rst memreq", {31'b0, bus.mem_req_o}, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Vector table: request cycle, then zero-wait release
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      drive_req(vecs[i].we, vecs[i].size, vecs[i].addr, vecs[i].wd);
      #1;
      check($sformatf("%s err", vecs[i].name), {31'b0, bus.lsu_err_o}, {31'b0, vecs[i].err});
      check($sformatf("%s memreq", vecs[i].name), {31'b0, bus.mem_req_o}, {31'b0, ~vecs[i].err});
      check($sformatf("%s stall", vecs[i].name), {31'b0, bus.core_stall_o}, {31'b0, ~vecs[i].err});
      check($sformatf("%s be", vecs[i].name), {28'b0, bus.mem_be_o}, {28'b0, vecs[i].be});
      check($sformatf("%s wd", vecs[i].name), bus.mem_wd_o, vecs[i].wdx);
      if (!vecs[i].err) begin
        exp_q.push_back(vecs[i].rdx);
        check($sformatf("%s addr", vecs[i].name), bus.mem_addr_o, {vecs[i].addr[31:2], 2'b00});
        check($sformatf("%s we", vecs[i].name), {31'b0, bus.mem_we_o}, {31'b0, vecs[i].we});
        @(negedge clk);
        bus.mem_ready_i = 1'b1;
        bus.mem_rd_i    = vecs[i].rdw;
        #1;
        check($sformatf("%s rel stall", vecs[i].name), {31'b0, bus.core_stall_o}, 32'h0);
        check($sformatf("%s rel memreq", vecs[i].name), {31'b0, bus.mem_req_o}, 32'h0);
        sb_check($sformatf("%s rd", vecs[i].name));
      end
      @(negedge clk);
      drive_idle();
    end

    // Three wait states: one request pulse, four stall cycles, then release
    @(negedge clk);
    drive_req(1'b0, 3'd2, 32'h0000_0104, 32'h0);
    exp_q.push_back(32'h1122_3344);
    #1;
    check("ws3 memreq first", {31'b0, bus.mem_req_o}, 32'h1);
    stalls = bus.core_stall_o ? 1 : 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      if (bus.core_stall_o) stalls++;
      check($sformatf("ws3 memreq w%0d", k), {31'b0, bus.mem_req_o}, 32'h0);
    end
    check("ws3 stall cycles", stalls, 4);
    @(negedge clk);
    bus.mem_ready_i = 1'b1;
    bus.mem_rd_i    = 32'h1122_3344;
    #1;
    check("ws3 rel stall", {31'b0, bus.core_stall_o}, 32'h0);
    sb_check("ws3 rd");
    @(negedge clk);
    drive_idle();

    // Timeout with limit 4: four stalling WAIT cycles, error on the fifth
    @(negedge clk);
    drive_req(1'b0, 3'd2, 32'h0000_0108, 32'h0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      #1;
      check($sformatf("to stall w%0d", k), {31'b0, bus.core_stall_o}, 32'h1);
      check($sformatf("to noerr w%0d", k), {31'b0, bus.lsu_err_o}, 32'h0);
    end
    @(negedge clk);
    #1;
    check("to err", {31'b0, bus.lsu_err_o}, 32'h1);
    check("to stall drop", {31'b0, bus.core_stall_o}, 32'h0);
    check("to rd", bus.core_rd_o, 32'h0);
    drive_idle();
    @(negedge clk);
    #1;
    check("to idle", {31'b0, dbg}, 32'h0);
    check("to err pulse", {31'b0, bus.lsu_err_o}, 32'h0);

    // Reset asserted mid-WAIT while the core still presents a valid request
    @(negedge clk);
    drive_req(1'b0, 3'd2, 32'h0000_0110, 32'h0);
    @(negedge clk);
    #1;
    check("rw in wait", {31'b0, dbg}, 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rw memreq", {31'b0, bus.mem_req_o}, 32'h0);
    check("rw stall", {31'b0, bus.core_stall_o}, 32'h0);
    check("rw err", {31'b0, bus.lsu_err_o}, 32'h0);
    check("rw state", {31'b0, dbg}, 32'h0);
    check("rw addr", bus.mem_addr_o, 32'h0);
    @(negedge clk);
    drive_idle();
    rst_n = 1'b1;
    @(negedge clk);
    bus.mem_ready_i = 1'b1;
    bus.mem_rd_i    = 32'hFFFF_FFFF;
    #1;
    check("late ready rd", bus.core_rd_o, 32'h0);
    check("late ready stall", {31'b0, bus.core_stall_o}, 32'h0);
    check("late ready state", {31'b0, dbg}, 32'h0);
    @(negedge clk);
    drive_idle();

    // Back-to-back: new request accepted in the cycle right after release
    @(negedge clk);
    drive_req(1'b0, 3'd4, 32'h0000_0102, 32'h0);
    exp_q.push_back(32'h0000_00AB);
    @(negedge clk);
    bus.mem_ready_i = 1'b1;
    bus.mem_rd_i    = 32'h00AB_0000;
    #1;
    sb_check("b2b lbu rd");
    @(negedge clk);
    bus.mem_ready_i = 1'b0;
    bus.mem_rd_i    = 32'h0;
    drive_req(1'b1, 3'd2, 32'h0000_0114, 32'h55AA_55AA);
    #1;
    check("b2b memreq", {31'b0, bus.mem_req_o}, 32'h1);
    check("b2b we", {31'b0, bus.mem_we_o}, 32'h1);
    check("b2b wd", bus.mem_wd_o, 32'h55AA_55AA);
    @(negedge clk);
    bus.mem_ready_i = 1'b1;
    #1;
    check("b2b sw stall", {31'b0, bus.core_stall_o}, 32'h0);
    check("b2b sw rd", bus.core_rd_o, 32'h0);
    @(negedge clk);
    drive_idle();
    @(negedge clk);

    // Final report
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/riscv_lsu.md
# riscv_lsu

Load-store unit between the `riscv_core` data-memory port and `data_mem`. It turns the core's byte-addressed, sized requests into word-aligned memory accesses with byte enables and replicated store data. It sign- or zero-extends load data back to the core. It owns the stall handshake: it asserts `core_stall_o` while an access is outstanding and supports memories with variable wait states.

## Interface
- `TIMEOUT_CYCLES`, default 255: maximum WAIT cycles before the access is aborted with an error. 0 disables the timeout.
- `clk_i` input 1: clock; all state updates on rising edge.
- `rst_i` input 1: reset, asynchronous, active-low.
- `core_req_i` input 1: core requests a data access. The core holds all `core_*` inputs stable while `core_stall_o`=1.
- `core_we_i` input 1: 1 = store, 0 = load.
- `core_size_i` input 3: funct3 encoding. 0 = B, 1 = H, 2 = W, 4 = BU, 5 = HU. 3, 6 and 7 are invalid.
- `core_addr_i` input 32: byte address.
- `core_wd_i` input 32: store data, right-aligned.
- `core_rd_o` output 32: extended load data. Valid only in the release cycle.
- `core_stall_o` output 1: core must hold the current instruction.
- `lsu_err_o` output 1: one-cycle pulse on a misaligned access, invalid size, or timeout.
- `mem_req_o` output 1: memory request, single-cycle pulse.
- `mem_we_o` output 1: memory write enable; qualified by `mem_req_o`.
- `mem_be_o` output 4: byte enables.
- `mem_addr_o` output 32: `{core_addr_i[31:2],2'b00}`.
- `mem_wd_o` output 32: replicated store data.
- `mem_rd_i` input 32: memory read word.
- `mem_ready_i` input 1: memory completed the access. Earliest assertion is the cycle after `mem_req_o`.

## Operation
- States: IDLE and WAIT. Reset state is IDLE.
- Validity check in IDLE: a request is valid when the size is legal and the address is aligned.
  - H/HU requires `addr[0]`=0.
  - W requires `addr[1:0]`=0.
- IDLE with `core_req_i`=1 and a valid request:
  - Assert `mem_req_o`=1 and `core_stall_o`=1.
  - Latch `core_we_i`, `core_size_i` and `core_addr_i[1:0]`.
  - Clear the timeout counter and go to WAIT.
- IDLE with `core_req_i`=1 and an invalid request:
  - `lsu_err_o`=1 for that cycle.
  - `mem_req_o`=0 and `core_stall_o`=0.
  - Stay in IDLE.
- IDLE with `core_req_i`=0: all outputs are idle and `mem_ready_i` is ignored.
- WAIT with `mem_ready_i`=0:
  - `core_stall_o`=1 and the counter increments.
  - If TIMEOUT_CYCLES≠0 and the counter reaches TIMEOUT_CYCLES: `lsu_err_o`=1, `core_stall_o`=0, go to IDLE.
- WAIT with `mem_ready_i`=1 (release cycle):
  - `core_stall_o`=0.
  - For loads, `core_rd_o` = extended `mem_rd_i`.
  - Go to IDLE.
  - `mem_ready_i` takes priority over a timeout in the same cycle.
- Byte enables are computed from `core_size_i`/`core_addr_i` in IDLE and driven for both loads and stores:
  - B/BU: `4'b0001 << addr[1:0]`.
  - H/HU: `4'b0011 << addr[1:0]`.
  - W: `4'b1111`.
- Store data on `mem_wd_o`:
  - B: `{4{wd[7:0]}}`.
  - H: `{2{wd[15:0]}}`.
  - W: `wd`.
- Load extraction uses the latched offset `off` and latched size:
  - Shift `mem_rd_i` right by 8·off.
  - B/H sign-extend bit 7/15.
  - BU/HU zero-extend.
  - W passes through unchanged.
- When not in the release cycle, `core_rd_o` = 0.
- The memory-side outputs `mem_we_o`, `mem_be_o` and `mem_wd_o` are 0 whenever `mem_req_o`=0.

## Timing
- Reset (asynchronous, `rst_i`=0) takes effect immediately, including mid-WAIT:
  - State → IDLE; latched fields and counter → 0.
  - `mem_req_o`, `core_stall_o` and `lsu_err_o` go to 0 combinationally.
  - All outputs are 0.
- An outstanding memory response after reset is ignored, because `mem_ready_i` is ignored in IDLE.
- Zero-wait memory (`mem_ready_i` the cycle after the request): one stall cycle, then release. This matches the existing single-cycle `data_mem` behaviour.
- N wait states: stall for N+1 cycles, release on cycle N+1.
- The maximum stall is TIMEOUT_CYCLES+1 cycles.
- A back-to-back request in the cycle after release is accepted from IDLE with no bubble.
- The counter is 8 bits wide, sized to hold TIMEOUT_CYCLES, and saturates without wrapping.

## Test plan
- LW at 0x100, `mem_rd_i`=0xDEADBEEF, ready 1 cycle after request:
  - Expect `mem_be_o`=1111 and `mem_addr_o`=0x100.
  - Expect a stall of 1 cycle, then `core_rd_o`=0xDEADBEEF with stall=0.
- LB and LBU at 0x103, `mem_rd_i`=0x80000000:
  - LB → `core_rd_o`=0xFFFFFF80.
  - LBU → `core_rd_o`=0x00000080.
  - Both with `mem_be_o`=1000.
- SH at 0x102, `core_wd_i`=0x1234ABCD:
  - Expect `mem_we_o`=1, `mem_be_o`=1100, `mem_wd_o`=0xABCDABCD, `mem_addr_o`=0x100.
- LW at 0x102 and size=3:
  - Each gives `lsu_err_o`=1 for one cycle, `mem_req_o`=0 and `core_stall_o`=0.
- 3 wait states:
  - Stall held for 4 cycles, one `mem_req_o` pulse only, release on the 4th cycle.
  - With TIMEOUT_CYCLES=4 and no ready: `lsu_err_o` after 4 WAIT cycles, then IDLE.
- Reset asserted in WAIT:
  - Outputs go to 0 before the next edge.
  - A late `mem_ready_i` after reset is released produces no `core_rd_o` and no stall.
